sysref_sync_ctrl: RTL and testbench

Sequencer for the PL SYSREF capture path. It takes the SYSREF sample already registered in the `pl_clk` domain and arms a capture window. It then qualifies successive rising edges against an expected period and declares lock after a programmable run of good periods. Once locked, it issues per-edge sync pulses and an optionally gated SYSREF to the RF-ADC/RF-DAC alignment logic, and reports timeout or period errors back to software.

---
 rtl/sysref_sync_ctrl_if.sv | 26 ++
 rtl/sysref_sync_ctrl.sv | 151 +++++++++++++++
 tb/tb_sysref_sync_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sysref_sync_ctrl_if.sv
// Control/status bundle between the software-facing side and the SYSREF sequencer.
interface sysref_sync_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             sysref_in;
    logic             arm;
    logic             abort;
    logic             busy;
    logic             locked;
    logic             err;
    logic [1:0]       err_code;
    logic             sync_pulse;
    logic             sysref_gated;
    logic [7:0]       edge_count;
    logic [CNT_W-1:0] last_period;

    modport master (
        output sysref_in, arm, abort,
        input  busy, locked, err, err_code, sync_pulse, sysref_gated, edge_count, last_period
    );

    modport slave (
        input  sysref_in, arm, abort,
        output busy, locked, err, err_code, sync_pulse, sysref_gated, edge_count, last_period
    );
endinterface

// File: rtl/sysref_sync_ctrl.sv
// SYSREF capture sequencer: arms on request, qualifies edge-to-edge periods, locks, issues sync pulses.
// Optional build macro SYSREF_GATE_EN forwards SYSREF to the converters only while locked.
module sysref_sync_ctrl #(
    parameter int CNT_W      = 16,
    parameter int PERIOD     = 256,
    parameter int TOL        = 2,
    parameter int LOCK_EDGES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic              pl_clk,
    input  logic              pl_rst_n,
    sysref_sync_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_MEASURE,
        ST_LOCKED,
        ST_ERROR
    } state_t;

    localparam logic [1:0]     ERR_NONE    = 2'b00;
    localparam logic [1:0]     ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]     ERR_PERIOD  = 2'b10;
    // Period window is evaluated one bit wider than the counter so PERIOD+TOL never wraps.
    localparam logic [CNT_W:0] LP_LO       = (CNT_W+1)'((PERIOD > TOL) ? PERIOD - TOL : 0);
    localparam logic [CNT_W:0] LP_HI       = (CNT_W+1)'(PERIOD + TOL);
    localparam logic [CNT_W:0] LP_TIMEOUT  = (CNT_W+1)'(TIMEOUT);
    localparam logic [CNT_W:0] LP_ONE_W    = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);
    localparam logic [7:0]     LP_LOCK     = 8'(LOCK_EDGES);

    state_t           r_state, w_state_nxt;
    logic             r_sysref_q;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W:0]   w_meas;
    logic             w_edge, w_good, w_timeout;
    logic [7:0]       r_edge_count, w_edge_count_nxt, w_count_inc;
    logic [1:0]       r_err_code, w_err_code_nxt;
    logic [CNT_W-1:0] r_last_period, w_last_period_nxt;
    logic             r_busy, r_locked, r_err;
    logic             r_sync_pulse, w_sync_nxt;
    logic             r_sysref_gated, w_gated_nxt;
    logic             w_locked_nxt;

    assign w_edge       = bus.sysref_in & ~r_sysref_q;
    assign w_meas       = {1'b0, r_cnt} + LP_ONE_W;
    assign w_good       = (w_meas >= LP_LO) && (w_meas <= LP_HI);
    assign w_timeout    = (w_meas >= LP_TIMEOUT);
    assign w_count_inc  = (r_edge_count == 8'hFF) ? 8'hFF : r_edge_count + 8'd1;
    assign w_locked_nxt = (w_state_nxt == ST_LOCKED);

`ifdef SYSREF_GATE_EN
    // Requiring locked both before and after keeps the lock-completing edge and the failing edge out.
    assign w_gated_nxt = bus.sysref_in & r_locked & w_locked_nxt;
`else
    assign w_gated_nxt = bus.sysref_in;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        w_state_nxt       = r_state;
        w_err_code_nxt    = r_err_code;
        w_edge_count_nxt  = r_edge_count;
        w_last_period_nxt = r_last_period;
        w_sync_nxt        = 1'b0;
        w_cnt_nxt         = w_edge ? '0 : ((r_cnt == '1) ? r_cnt : r_cnt + LP_ONE);

        if (bus.abort) begin
            w_state_nxt      = ST_IDLE;
            w_err_code_nxt   = ERR_NONE;
            w_edge_count_nxt = 8'd0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_ERROR: begin
                    if (bus.arm) begin
                        w_state_nxt      = ST_ARMED;
                        w_err_code_nxt   = ERR_NONE;
                        w_edge_count_nxt = 8'd0;
                        w_cnt_nxt        = '0;
                    end
                end
                ST_ARMED: begin
                    if (w_edge) begin
                        w_state_nxt = ST_MEASURE;
                    end else if (w_timeout) begin
                        w_state_nxt    = ST_ERROR;
                        w_err_code_nxt = ERR_TIMEOUT;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (w_edge) begin
                        w_last_period_nxt = w_meas[CNT_W] ? '1 : w_meas[CNT_W-1:0];
                        if (w_good) begin
                            w_edge_count_nxt = w_count_inc;
                            if (r_state == ST_LOCKED || w_count_inc == LP_LOCK) begin
                                w_state_nxt = ST_LOCKED;
                                w_sync_nxt  = 1'b1;
                            end
                        end else begin
                            w_state_nxt    = ST_ERROR;
                            w_err_code_nxt = ERR_PERIOD;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt    = ST_ERROR;
                        w_err_code_nxt = ERR_TIMEOUT;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            r_state        <= ST_IDLE;
            r_sysref_q     <= 1'b0;
            r_cnt          <= '0;
            r_edge_count   <= 8'd0;
            r_err_code     <= ERR_NONE;
            r_last_period  <= '0;
            r_busy         <= 1'b0;
            r_locked       <= 1'b0;
            r_err          <= 1'b0;
            r_sync_pulse   <= 1'b0;
            r_sysref_gated <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sysref_q     <= bus.sysref_in;
            r_cnt          <= w_cnt_nxt;
            r_edge_count   <= w_edge_count_nxt;
            r_err_code     <= w_err_code_nxt;
            r_last_period  <= w_last_period_nxt;
            r_busy         <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_MEASURE) || w_locked_nxt;
            r_locked       <= w_locked_nxt;
            r_err          <= (w_state_nxt == ST_ERROR);
            r_sync_pulse   <= w_sync_nxt;
            r_sysref_gated <= w_gated_nxt;
        end
    end

    assign bus.busy         = r_busy;
    assign bus.locked       = r_locked;
    assign bus.err          = r_err;
    assign bus.err_code     = r_err_code;
    assign bus.sync_pulse   = r_sync_pulse;
    assign bus.sysref_gated = r_sysref_gated;
    assign bus.edge_count   = r_edge_count;
    assign bus.last_period  = r_last_period;
endmodule

// File: tb/tb_sysref_sync_ctrl.sv
// Scoreboard bench for sysref_sync_ctrl: a timestamp-based reference model predicts every cycle's outputs.
// Honours SYSREF_GATE_EN the same way as the design build.
module tb_sysref_sync_ctrl;
    localparam int CNT_W      = 16;
    localparam int PERIOD     = 16;
    localparam int TOL        = 1;
    localparam int LOCK_EDGES = 3;
    localparam int TIMEOUT    = 64;

    typedef struct packed {
        logic        busy;
        logic        locked;
        logic        err;
        logic [1:0]  code;
        logic        sync;
        logic        gated;
        logic [7:0]  ec;
        logic [15:0] last;
    } obs_t;

    logic pl_clk   = 1'b0;
    logic pl_rst_n = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   t        = 0;
    obs_t exp_q[$];

    // Reference model: session flag plus timestamps of the reference point (arm or last edge).
    bit   m_active, m_seen, m_prev_s;
    int   m_good, m_code, m_ref, m_last;

    sysref_sync_ctrl_if #(.CNT_W(CNT_W)) bus ();

    sysref_sync_ctrl #(
        .CNT_W(CNT_W), .PERIOD(PERIOD), .TOL(TOL), .LOCK_EDGES(LOCK_EDGES), .TIMEOUT(TIMEOUT)
    ) dut (
        .pl_clk  (pl_clk),
        .pl_rst_n(pl_rst_n),
        .bus     (bus)
    );

    always #5 pl_clk = ~pl_clk;

    function automatic obs_t sample();
        obs_t o;
        o.busy   = bus.busy;
        o.locked = bus.locked;
        o.err    = bus.err;
        o.code   = bus.err_code;
        o.sync   = bus.sync_pulse;
        o.gated  = bus.sysref_gated;
        o.ec     = bus.edge_count;
        o.last   = bus.last_period;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got busy=%b lock=%b err=%b code=%b sync=%b gated=%b ec=%0d last=%0d want busy=%b lock=%b err=%b code=%b sync=%b gated=%b ec=%0d last=%0d",
                     name, t, act.busy, act.locked, act.err, act.code, act.sync, act.gated, act.ec, act.last,
                     exp.busy, exp.locked, exp.err, exp.code, exp.sync, exp.gated, exp.ec, exp.last);
        end
    endtask

    // One clock of stimulus; the model predicts the outputs visible after the next rising edge.
    task automatic cycle(input logic s, input logic a, input logic ab);
        bit   edge_s, was_locked, sync_e;
        int   per;
        obs_t e;
        @(negedge pl_clk);
        bus.sysref_in = s;
        bus.arm       = a;
        bus.abort     = ab;
        edge_s     = s && !m_prev_s;
        m_prev_s   = s;
        was_locked = m_active && (m_good >= LOCK_EDGES);
        sync_e     = 1'b0;
        if (ab) begin
            m_active = 0; m_code = 0; m_good = 0;
        end else if (!m_active) begin
            if (a) begin
                m_active = 1; m_seen = 0; m_code = 0; m_good = 0; m_ref = t;
            end
        end else if (edge_s && !m_seen) begin
            m_seen = 1; m_ref = t;
        end else if (edge_s) begin
            per    = t - m_ref;
            m_last = per;
            m_ref  = t;
            if (per >= PERIOD - TOL && per <= PERIOD + TOL) begin
                m_good++;
                sync_e = (m_good >= LOCK_EDGES);
            end else begin
                m_active = 0; m_code = 2;
            end
        end else if (t - m_ref >= TIMEOUT) begin
            m_active = 0; m_code = 1;
        end
        e.busy   = m_active;
        e.locked = m_active && (m_good >= LOCK_EDGES);
        e.err    = (m_code != 0);
        e.code   = 2'(m_code);
        e.sync   = sync_e;
`ifdef SYSREF_GATE_EN
        e.gated  = s && was_locked && e.locked;
`else
        e.gated  = s;
`endif
        e.ec     = 8'((m_good > 255) ? 255 : m_good);
        e.last   = 16'(m_last);
        exp_q.push_back(e);
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // One edge followed by enough low cycles to make the next edge p cycles later.
    task automatic pulse_period(input int p, input int w);
        for (int i = 0; i < p; i++) cycle(i < w, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_active = 0; m_seen = 0; m_prev_s = 0;
        m_good = 0; m_code = 0; m_ref = 0; m_last = 0;
    endtask

    // Drop reset between clock edges and require all outputs to clear before the next rising edge.
    task automatic async_reset(input int hold);
        @(negedge pl_clk);
        #2;
        pl_rst_n = 1'b0;
        #1;
        check("async_reset", sample(), '0);
        bus.sysref_in = 1'b0;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        repeat (hold) @(negedge pl_clk);
        pl_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic nominal_lock(input int extra);
        cycle(1'b0, 1'b1, 1'b0);
        idle(9);
        for (int i = 0; i < 4 + extra; i++) pulse_period(PERIOD, (i % 3) + 1);
    endtask

    task automatic rand_run(input int n);
        int cd = 7, w = 1, ph = 0, r;
        for (int i = 0; i < n; i++) begin
            logic s, a, ab;
            s  = (ph < w);
            a  = ($urandom_range(0, 39) == 0);
            ab = ($urandom_range(0, 249) == 0);
            cycle(s, a, ab);
            ph++;
            if (ph >= cd) begin
                ph = 0;
                w  = $urandom_range(1, 3);
                r  = $urandom_range(0, 19);
                if (r < 14)      cd = $urandom_range(PERIOD - TOL, PERIOD + TOL);
                else if (r < 17) cd = ($urandom_range(0, 1) != 0) ? PERIOD - TOL - 1 : PERIOD + TOL + 1;
                else             cd = $urandom_range(TIMEOUT - 14, TIMEOUT + 6);
            end
        end
    endtask

    // Monitor: compares the oldest prediction against the DUT just after each rising edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge pl_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", sample(), e);
            end
        end
    end

    initial begin
        bus.sysref_in = 1'b0;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        model_reset();
        #3;
        check("reset_state", sample(), '0);
        @(negedge pl_clk);
        pl_rst_n = 1'b1;

        idle(4);
        nominal_lock(2);
        cycle(1'b0, 1'b0, 1'b1);

        // Periods 15 and 17 accepted, then 18 fails.
        cycle(1'b0, 1'b1, 1'b0);
        idle(4);
        pulse_period(PERIOD - TOL, 1);
        pulse_period(PERIOD + TOL, 2);
        pulse_period(PERIOD + TOL + 1, 1);
        pulse_period(PERIOD, 1);
        idle(4);

        // Timeout with no edges, then re-arm clears the error.
        cycle(1'b0, 1'b1, 1'b0);
        idle(70);
        cycle(1'b0, 1'b1, 1'b0);
        idle(3);

        // abort beats arm while locked.
        cycle(1'b0, 1'b0, 1'b1);
        nominal_lock(1);
        cycle(1'b0, 1'b1, 1'b1);
        idle(3);

        // First edge exactly at the timeout count is an edge.
        cycle(1'b0, 1'b1, 1'b0);
        idle(TIMEOUT - 1);
        for (int i = 0; i < 4; i++) pulse_period(PERIOD, 2);
        // Measured period equal to TIMEOUT is a period error.
        pulse_period(TIMEOUT, 1);
        cycle(1'b1, 1'b0, 1'b0);
        idle(3);

        // Edge on the arm cycle is ignored.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        idle(5);
        for (int i = 0; i < 5; i++) pulse_period(PERIOD, 1);
        cycle(1'b0, 1'b0, 1'b1);

        // Reset mid-lock, then full relock.
        nominal_lock(1);
        idle(3);
        async_reset(3);
        idle(3);
        nominal_lock(1);
        cycle(1'b0, 1'b0, 1'b1);

        rand_run(2500);

        repeat (3) @(negedge pl_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
